// File: rtl/playback_sequencer.sv
// playback_sequencer
//   Sequences a record/playback datapath built around an external FIFO.
//   A save press in IDLE writes din into the FIFO. An execute press drains
//   the FIFO, holding each entry on play_data for STEP_TICKS cycles.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   save         record button (level)
//   execute      playback button (level)
//   cancel       abort playback (level)
//   din          word to record
//   fifo_full    FIFO full flag
//   fifo_empty   FIFO empty flag
//   fifo_rdata   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_wr_en   one-cycle FIFO write strobe
//   fifo_wdata   FIFO write data, valid with fifo_wr_en
//   fifo_rd_en   one-cycle FIFO read strobe
//   play_valid   high while an entry is being played
//   play_data    entry being played (holds last value after playback)
//   busy         high in any state other than IDLE
//   overflow     sticky: a save was dropped because the FIFO was full
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for save/execute presses; saves are handled here
// FETCH | fifo_rd_en is high this cycle
// LOAD  | fifo_rdata is valid; latch it and arm the step counter
// PLAY  | entry presented on play_data until the counter reaches 0
module playback_sequencer #(
  parameter int DATA_W     = 8,
  parameter int STEP_TICKS = 50_000_000,
  parameter int CNT_W      = $clog2(STEP_TICKS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save,
  input  logic              execute,
  input  logic              cancel,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wdata,
  output logic              fifo_rd_en,
  output logic              play_valid,
  output logic [DATA_W-1:0] play_data,
  output logic              busy,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_TICKS - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              save_q, exec_q;
  logic              save_rise, exec_rise;
  logic              wr_en_nxt, rd_en_nxt, play_valid_nxt, overflow_nxt;
  logic [DATA_W-1:0] wdata_nxt, play_data_nxt;

  assign save_rise = save & ~save_q;
  assign exec_rise = execute & ~exec_q;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    wr_en_nxt      = 1'b0;
    rd_en_nxt      = 1'b0;
    play_valid_nxt = 1'b0;
    overflow_nxt   = overflow;
    wdata_nxt      = fifo_wdata;
    play_data_nxt  = play_data;
    case (state)
      IDLE: begin
        // save wins over a simultaneous execute edge
        if (save_rise) begin
          if (!fifo_full) begin
            wr_en_nxt = 1'b1;
            wdata_nxt = din;
          end else begin
            overflow_nxt = 1'b1;
          end
        end else if (exec_rise && !fifo_empty) begin
          state_nxt = FETCH;
          rd_en_nxt = 1'b1;
        end
      end
      FETCH: begin
        // a read issued here is not undone by cancel; that entry is lost
        state_nxt = cancel ? IDLE : LOAD;
      end
      LOAD: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else begin
          play_data_nxt  = fifo_rdata;
          cnt_nxt        = CNT_LOAD;
          play_valid_nxt = 1'b1;
          state_nxt      = PLAY;
        end
      end
      PLAY: begin
        if (cancel) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          if (!fifo_empty) begin
            state_nxt = FETCH;
            rd_en_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt        = cnt - CNT_W'(1);
          play_valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      // edge detectors start high so a button held through reset is ignored
      save_q     <= 1'b1;
      exec_q     <= 1'b1;
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      fifo_rd_en <= 1'b0;
      play_valid <= 1'b0;
      play_data  <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      save_q     <= save;
      exec_q     <= execute;
      fifo_wr_en <= wr_en_nxt;
      fifo_wdata <= wdata_nxt;
      fifo_rd_en <= rd_en_nxt;
      play_valid <= play_valid_nxt;
      play_data  <= play_data_nxt;
      busy       <= (state_nxt != IDLE);
      overflow   <= overflow_nxt;
    end
  end

endmodule
